// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler that shares one registered ALU between NUM_REQ requesters.
// Each accepted operation runs operand load, then result capture, then a held response, then back to idle.
module alu_req_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 8,
    parameter int OP_W       = 4,
    parameter int CNT_W      = 16,
    parameter int CPU_STATES = 8,
    parameter int CS_W       = (CPU_STATES > 1) ? $clog2(CPU_STATES) : 1,
    parameter logic [CS_W-1:0] EXECUTE1 = CS_W'(3),
    parameter logic [CS_W-1:0] EXECUTE2 = CS_W'(4),
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      sys_clk,
    input  logic                      sys_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_greater,
    output logic                      rsp_equal,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          ops_done,
    output logic [DATA_W-1:0]         A_bus,
    output logic [DATA_W-1:0]         B_bus,
    output logic                      alu_en_A_reg,
    output logic                      alu_en_B_reg,
    output logic [OP_W-1:0]           alu_op,
    output logic [CS_W-1:0]           cpu_state,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      cc_greater,
    input  logic                      cc_equal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     grant_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic                alu_en_q;
    logic [CS_W-1:0]     cpu_state_q;
    logic                busy_q;
    logic [CNT_W-1:0]    ops_done_q;

    logic                win_vld;
    logic [ID_W-1:0]     win_id;
    logic [ID_W:0]       cand;
    logic                accept;
    logic                rsp_take;
    logic [ID_W-1:0]     rr_ptr_d;
    logic [CNT_W-1:0]    ops_done_d;

    // Search starts at rr_ptr and wraps; the first valid requester found wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!win_vld && req_valid[cand[ID_W-1:0]]) begin
                win_vld = 1'b1;
                win_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && win_vld) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign accept     = (state_q == S_IDLE) && win_vld;
    assign rsp_take   = (state_q == S_RESP) && rsp_ready[grant_q];
    assign rr_ptr_d   = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    assign ops_done_d = ops_done_q + CNT_W'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= '0;
            alu_en_q    <= 1'b0;
            cpu_state_q <= '0;
            busy_q      <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= req_op[int'(win_id)*OP_W +: OP_W];
                        a_q         <= req_a[int'(win_id)*DATA_W +: DATA_W];
                        b_q         <= req_b[int'(win_id)*DATA_W +: DATA_W];
                        grant_q     <= win_id;
                        rr_ptr_q    <= rr_ptr_d;
                        alu_en_q    <= 1'b1;
                        cpu_state_q <= EXECUTE1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cpu_state_q <= EXECUTE2;
                    state_q     <= S_EXEC;
                end
                S_EXEC: begin
                    // The ALU captures its result on this edge, so the response opens next cycle.
                    alu_en_q    <= 1'b0;
                    cpu_state_q <= '0;
                    rsp_valid_q <= NUM_REQ'(1) << grant_q;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_take) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        ops_done_q  <= ops_done_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = (|rsp_valid_q) ? alu_result : '0;
    assign rsp_greater  = (|rsp_valid_q) & cc_greater;
    assign rsp_equal    = (|rsp_valid_q) & cc_equal;
    assign grant_id     = grant_q;
    assign busy         = busy_q;
    assign ops_done     = ops_done_q;
    assign A_bus        = a_q;
    assign B_bus        = b_q;
    assign alu_op       = op_q;
    assign alu_en_A_reg = alu_en_q;
    assign alu_en_B_reg = alu_en_q;
    assign cpu_state    = cpu_state_q;

endmodule
